// File: rtl/frame_sync_packer.sv
// frame_sync_packer: hunts a sync word in a 1-bit-per-beat AXI-Stream, then packs
// the following PAYLOAD_BYTES*8 bits MSB-first into bytes emitted as an AXI-Stream frame.
module frame_sync_packer #(
  parameter int unsigned           C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned           C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned           SYNC_WIDTH             = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD              = 16'h1ACF,
  parameter int unsigned           MAX_ERRS               = 0,
  parameter int unsigned           PAYLOAD_BYTES          = 8
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  locked,
  output logic                                  frame_abort
);

  localparam int unsigned FILL_W = $clog2(SYNC_WIDTH + 1);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

  typedef enum logic {
    ST_SEARCH  = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t                  state;
  logic [SYNC_WIDTH-1:0]   shreg;
  logic [FILL_W-1:0]       fill;
  logic [2:0]              bit_cnt;
  logic [CNT_W-1:0]        byte_cnt;
  logic [7:0]              byte_sr;

  logic                    accept;
  logic                    in_bit;
  logic [SYNC_WIDTH-1:0]   shreg_nxt;
  logic [FILL_W-1:0]       fill_nxt;
  logic                    sync_hit;
  logic [7:0]              byte_nxt;
  logic                    byte_done;
  logic                    last_byte;
  logic                    frame_end;
  logic                    unused_inputs;

  // Number of set bits in a sync-width vector (Hamming weight).
  function automatic int unsigned popcount(input logic [SYNC_WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < SYNC_WIDTH; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Only tdata[0] carries information; the remaining input lanes are don't-care.
  assign unused_inputs = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1], s00_axis_tstrb};

  // Input may advance whenever the single output slot is empty or draining this cycle.
  assign s00_axis_tready = ~m00_axis_tvalid | m00_axis_tready;
  assign accept          = s00_axis_tvalid & s00_axis_tready;
  assign in_bit          = s00_axis_tdata[0];

  // Sync detection on the shift register including the bit being accepted now.
  assign shreg_nxt = {shreg[SYNC_WIDTH-2:0], in_bit};
  assign fill_nxt  = (fill == FILL_W'(SYNC_WIDTH)) ? fill : fill + FILL_W'(1);
  assign sync_hit  = (fill_nxt == FILL_W'(SYNC_WIDTH)) &&
                     (popcount(shreg_nxt ^ SYNC_WORD) <= MAX_ERRS);

  // Byte assembly: first payload bit of each byte ends up in bit 7.
  assign byte_nxt  = {byte_sr[6:0], in_bit};
  assign byte_done = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == CNT_W'(PAYLOAD_BYTES - 1));
  assign frame_end = byte_done & last_byte;

  // Hunt/pack state machine with the registered output slot.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state           <= ST_SEARCH;
      shreg           <= '0;
      fill            <= '0;
      bit_cnt         <= '0;
      byte_cnt        <= '0;
      byte_sr         <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      locked          <= 1'b0;
      frame_abort     <= 1'b0;
    end else begin
      frame_abort <= 1'b0;

      if (m00_axis_tvalid && m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
        m00_axis_tlast  <= 1'b0;
        m00_axis_tdata  <= '0;
        m00_axis_tstrb  <= '0;
      end

      if (accept) begin
        if (state == ST_SEARCH) begin
          if (sync_hit) begin
            state    <= ST_PAYLOAD;
            locked   <= 1'b1;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            fill     <= '0;
          end else begin
            shreg <= shreg_nxt;
            fill  <= fill_nxt;
          end
        end else begin
          byte_sr <= byte_nxt;
          bit_cnt <= bit_cnt + 3'd1;

          if (byte_done) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(byte_nxt);
            m00_axis_tstrb  <= STRB_W'(1);
            m00_axis_tlast  <= last_byte | s00_axis_tlast;
            byte_cnt        <= byte_cnt + CNT_W'(1);
          end

          // Frame ends on its final bit or is cut short by upstream tlast.
          if (frame_end || s00_axis_tlast) begin
            state       <= ST_SEARCH;
            locked      <= 1'b0;
            shreg       <= '0;
            fill        <= '0;
            frame_abort <= s00_axis_tlast & ~frame_end;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_packer.sv
// Bench for frame_sync_packer: two instances (MAX_ERRS 0 and 1) share one input stream
// and are checked every cycle against a bit-stream reference model, plus literal frame checks.
module tb_frame_sync_packer;

  localparam logic [15:0] SYNC = 16'h1ACF;
  localparam int          PB   = 8;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        m_tready;
  logic [1:0]  s_tready;
  logic [1:0]  m_tvalid;
  logic [1:0]  m_tlast;
  logic [1:0]  locked;
  logic [1:0]  frame_abort;
  logic [31:0] m_tdata [2];
  logic [3:0]  m_tstrb [2];

  int vectors     = 0;
  int miscompares = 0;
  int abort_cnt   = 0;

  // reference model state, one slot per instance (index == MAX_ERRS)
  bit       mv [2];
  bit       ml [2];
  bit [7:0] md [2];
  bit       lk [2];
  bit       ab [2];
  bit       acc_last [2];
  bit [15:0] hist [2];
  int       hn [2];
  int       nb [2];
  bit [7:0] cur [2];

  logic [7:0] cap_d [$];
  logic       cap_l [$];

  frame_sync_packer #(.MAX_ERRS(0)) u_dut0 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready[0]), .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid[0]), .m00_axis_tlast(m_tlast[0]),
    .m00_axis_tdata(m_tdata[0]), .m00_axis_tstrb(m_tstrb[0]),
    .locked(locked[0]), .frame_abort(frame_abort[0])
  );

  frame_sync_packer #(.MAX_ERRS(1)) u_dut1 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready[1]), .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid[1]), .m00_axis_tlast(m_tlast[1]),
    .m00_axis_tdata(m_tdata[1]), .m00_axis_tstrb(m_tstrb[1]),
    .locked(locked[1]), .frame_abort(frame_abort[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits are consumed when valid and the output slot is free or draining;
  // in hunt mode the last 16 bits are compared to SYNC, in frame mode bits are counted.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] = 0; ml[k] = 0; md[k] = 0; lk[k] = 0; ab[k] = 0; acc_last[k] = 0;
        hist[k] = 0; hn[k] = 0; nb[k] = 0; cur[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit fin;
        acc_last[k] = s_tvalid && (!mv[k] || m_tready);
        ab[k] = 0;
        if (mv[k] && m_tready) begin
          mv[k] = 0;
          ml[k] = 0;
        end
        if (acc_last[k]) begin
          if (!lk[k]) begin
            hist[k] = {hist[k][14:0], s_tdata[0]};
            if (hn[k] < 16) hn[k]++;
            if (hn[k] == 16 && $countones(hist[k] ^ SYNC) <= k) begin
              lk[k] = 1;
              nb[k] = 0;
            end
          end else begin
            cur[k] = {cur[k][6:0], s_tdata[0]};
            nb[k]++;
            fin = (nb[k] == PB * 8);
            if (nb[k] % 8 == 0) begin
              mv[k] = 1;
              md[k] = cur[k];
              ml[k] = fin || s_tlast;
            end
            if (fin || s_tlast) begin
              lk[k] = 0;
              hist[k] = 0;
              hn[k] = 0;
              ab[k] = s_tlast && !fin;
            end
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d m_tvalid", k), 32'(m_tvalid[k]), 32'(mv[k]));
      chk($sformatf("u%0d m_tstrb", k), 32'(m_tstrb[k]), mv[k] ? 32'd1 : 32'd0);
      if (mv[k]) begin
        chk($sformatf("u%0d m_tdata", k), m_tdata[k], {24'b0, md[k]});
        chk($sformatf("u%0d m_tlast", k), 32'(m_tlast[k]), 32'(ml[k]));
      end
      chk($sformatf("u%0d locked", k), 32'(locked[k]), 32'(lk[k]));
      chk($sformatf("u%0d frame_abort", k), 32'(frame_abort[k]), 32'(ab[k]));
      chk($sformatf("u%0d s_tready", k), 32'(s_tready[k]), 32'(!mv[k] || m_tready));
    end
    if (m_tvalid[0] && m_tready) begin
      cap_d.push_back(m_tdata[0][7:0]);
      cap_l.push_back(m_tlast[0]);
    end
    if (frame_abort[0]) abort_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Hold a bit on the input until instance 0 consumes it.
  task automatic send_bit(input logic b, input logic l);
    bit done;
    done     = 0;
    s_tvalid = 1'b1;
    s_tdata  = {31'b0, b};
    s_tlast  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (acc_last[0]) done = 1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL send_bit timeout: got no accept expected accept at %0t", $time);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] base);
    send_word(SYNC);
    for (int i = 0; i < PB; i++) send_byte(base + 8'(i));
  endtask

  task automatic check_bytes(input logic [7:0] base, input int off);
    for (int i = 0; i < PB; i++) begin
      if (off + i < cap_d.size()) begin
        chk($sformatf("lit byte %0d", off + i), 32'(cap_d[off+i]), 32'(base + 8'(i)));
        chk($sformatf("lit tlast %0d", off + i), 32'(cap_l[off+i]), 32'(i == PB - 1));
      end
    end
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
  endtask

  initial begin
    bit         pend [$];
    bit         use_p;
    logic [15:0] w;
    s_tstrb = 4'hF;
    do_reset();

    // reset state
    chk("rst m_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("rst locked", 32'(locked[0]), 32'd0);
    chk("rst m_tstrb", 32'(m_tstrb[0]), 32'd0);
    chk("rst frame_abort", 32'(frame_abort[0]), 32'd0);
    chk("rst s_tready", 32'(s_tready[0]), 32'd1);

    // 1: basic frame
    clear_cap();
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
    send_word(SYNC);
    chk("t1 locked after sync", 32'(locked[0]), 32'd1);
    for (int i = 0; i < PB - 1; i++) send_byte(8'(i));
    chk("t1 locked mid frame", 32'(locked[0]), 32'd1);
    send_byte(8'h07);
    chk("t1 unlocked at end", 32'(locked[0]), 32'd0);
    idle(3);
    chk("t1 byte count", cap_d.size(), 32'd8);
    check_bytes(8'h00, 0);

    // 2: backpressure after byte 2
    clear_cap();
    send_word(SYNC);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'd0;
    repeat (5) step();
    chk("t2 held tdata", m_tdata[0], 32'h0000_0002);
    chk("t2 held tvalid", 32'(m_tvalid[0]), 32'd1);
    chk("t2 s_tready low", 32'(s_tready[0]), 32'd0);
    m_tready = 1'b1;
    for (int i = 3; i < PB; i++) send_byte(8'(i));
    idle(3);
    chk("t2 byte count", cap_d.size(), 32'd8);
    check_bytes(8'h00, 0);

    // 3: tolerance of one bit error
    do_reset();
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
    send_word(SYNC ^ 16'h0008);
    chk("t3 1err u1 locked", 32'(locked[1]), 32'd1);
    chk("t3 1err u0 search", 32'(locked[0]), 32'd0);
    for (int i = 0; i < PB; i++) send_byte(8'(i));
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
    send_word(SYNC ^ 16'h0108);
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
    chk("t3 2err u1 search", 32'(locked[1]), 32'd0);
    chk("t3 2err u1 no out", 32'(m_tvalid[1]), 32'd0);

    // 4: abort after 12 payload bits
    clear_cap();
    abort_cnt = 0;
    send_word(SYNC);
    send_byte(8'hA5);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("t4 unlocked", 32'(locked[0]), 32'd0);
    idle(3);
    chk("t4 byte count", cap_d.size(), 32'd1);
    if (cap_d.size() > 0) begin
      chk("t4 byte", 32'(cap_d[0]), 32'hA5);
      chk("t4 tlast", 32'(cap_l[0]), 32'd0);
    end
    chk("t4 abort pulses", abort_cnt, 32'd1);
    clear_cap();
    send_frame(8'h10);
    idle(3);
    chk("t4 next frame count", cap_d.size(), 32'd8);
    check_bytes(8'h10, 0);

    // 5: async reset mid-payload with a byte held in the output slot
    send_word(SYNC);
    m_tready = 1'b0;
    send_byte(8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 tvalid at reset", 32'(m_tvalid[0]), 32'd0);
    chk("t5 locked at reset", 32'(locked[0]), 32'd0);
    step();
    rst_n    = 1'b1;
    m_tready = 1'b1;
    clear_cap();
    for (int i = 14; i >= 0; i--) send_bit(SYNC[i], 1'b0);
    idle(2);
    chk("t5 u0 no lock on tail", 32'(locked[0]), 32'd0);
    chk("t5 u1 no lock on tail", 32'(locked[1]), 32'd0);
    chk("t5 no output", cap_d.size(), 32'd0);

    // 6: back-to-back frames
    do_reset();
    clear_cap();
    send_frame(8'h40);
    send_frame(8'h50);
    idle(3);
    chk("t6 byte count", cap_d.size(), 32'd16);
    check_bytes(8'h40, 0);
    check_bytes(8'h50, 8);

    // randomized traffic with injected (sometimes corrupted) sync words
    for (int c = 0; c < 4000; c++) begin
      m_tready = ($urandom % 4) != 0;
      s_tvalid = ($urandom % 4) != 0;
      s_tlast  = ($urandom % 128) == 0;
      use_p    = pend.size() > 0;
      s_tdata  = {31'b0, use_p ? pend[0] : 1'($urandom % 2)};
      step();
      if (use_p && acc_last[0]) void'(pend.pop_front());
      if (pend.size() == 0 && ($urandom % 40) == 0) begin
        w = SYNC;
        if (($urandom % 3) == 0) w = w ^ (16'd1 << ($urandom % 16));
        for (int i = 15; i >= 0; i--) pend.push_back(w[i]);
      end
    end
    m_tready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
